// File: rtl/rgb_pkg.sv
// rgb_pkg: shared colour/RGB definitions for the colour lookup ROM and its clients.
// Contents: colour code width, RGB data width, ROM depth, colour enum and
// the RGB value stored at each colour code in the ROM init file.
package rgb_pkg;
    localparam int COLOUR_W  = 3;
    localparam int RGB_W     = 24;
    localparam int ROM_DEPTH = 8;

    typedef enum logic [COLOUR_W-1:0] {
        BLACK   = 3'd0,
        BLUE    = 3'd1,
        GREEN   = 3'd2,
        CYAN    = 3'd3,
        RED     = 3'd4,
        MAGENTA = 3'd5,
        YELLOW  = 3'd6,
        WHITE   = 3'd7
    } colour_e;

    localparam logic [RGB_W-1:0] RGB_BLACK   = 24'h000000;
    localparam logic [RGB_W-1:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [RGB_W-1:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [RGB_W-1:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [RGB_W-1:0] RGB_RED     = 24'hFF0000;
    localparam logic [RGB_W-1:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [RGB_W-1:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [RGB_W-1:0] RGB_WHITE   = 24'hFFFFFF;
endpackage

// File: rtl/rgb_lookup_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot winner selection with a last-winner pointer.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   cand        candidate requests (already qualified by enable/reset)
//   gnt         one-hot grant, combinational
//   grant_any   a winner exists this cycle
//   win_id      index of the winner (0 when none)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] cand,
    output logic [NUM_REQ-1:0] gnt,
    output logic               grant_any,
    output logic [ID_W-1:0]    win_id
);
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] idx;

    // Search starts one past the last winner and wraps, so the last winner
    // gets the lowest priority.
    always_comb begin
        grant_any = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_any && cand[idx]) begin
                grant_any = 1'b1;
                win_id    = idx;
            end
        end
        gnt   = grant_any ? (NUM_REQ'(1) << win_id) : '0;
        ptr_d = grant_any ? win_id : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/rgb_lookup_arbiter.sv
// rgb_lookup_arbiter: shares one colour->RGB ROM among NUM_REQ requesters.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   enable           0 blocks new grants; in-flight reads still complete
//   req, req_colour  per-requester level request and 3-bit colour code
//   gnt              one-hot grant, request consumed in the same cycle
//   rom_en, rom_addr ROM ena/addra (the parent ties wea/dina to 0)
//   rom_rdata        ROM douta, valid ROM_LATENCY edges after rom_en
//   rsp_valid/id/rgb tagged response, rgb forced to 0 when not valid
module rgb_lookup_arbiter
    import rgb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int ROM_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [COLOUR_W*NUM_REQ-1:0] req_colour,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        rom_en,
    output logic [COLOUR_W-1:0]         rom_addr,
    input  logic [RGB_W-1:0]            rom_rdata,
    output logic                        rsp_valid,
    output logic [ID_W-1:0]             rsp_id,
    output logic [RGB_W-1:0]            rsp_rgb
);
    logic [NUM_REQ-1:0]     cand;
    logic                   grant_any;
    logic [ID_W-1:0]        win_id;
    logic [ROM_LATENCY-1:0] vld_q, vld_d;
    logic [ID_W-1:0]        id_q [ROM_LATENCY];
    logic [ID_W-1:0]        id_d [ROM_LATENCY];

    // Gating with rst_n keeps gnt/rom_en low for the whole reset window.
    assign cand = req & {NUM_REQ{enable & rst_n}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .cand      (cand),
        .gnt       (gnt),
        .grant_any (grant_any),
        .win_id    (win_id)
    );

    always_comb begin
        rom_en   = grant_any;
        rom_addr = grant_any ? req_colour[int'(win_id)*COLOUR_W +: COLOUR_W] : '0;
    end

    // Tag pipeline mirrors the ROM latency; it never stalls.
    always_comb begin
        vld_d[0] = grant_any;
        id_d[0]  = win_id;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) id_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < ROM_LATENCY; i++) id_q[i] <= id_d[i];
        end
    end

    always_comb begin
        rsp_valid = vld_q[ROM_LATENCY-1];
        rsp_id    = id_q[ROM_LATENCY-1];
        rsp_rgb   = rsp_valid ? rom_rdata : '0;
    end
endmodule

// File: tb/tb_rgb_lookup_arbiter.sv
// tb_rgb_lookup_arbiter: directed bench with a response scoreboard for two
// configurations (4 requesters / latency 1, 3 requesters / latency 3).
module tb_rgb_lookup_arbiter;
    typedef struct {
        int          due;
        logic [1:0]  id;
        logic [23:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable = 1'b1;
    logic [3:0] req = '0;
    logic [2:0] b_req = '0;

    logic [2:0]  col_a [4] = '{3'd7, 3'd4, 3'd7, 3'd4};
    logic [2:0]  col_b [3] = '{3'd1, 3'd5, 3'd2};
    logic [23:0] rom_tbl [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                                 24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

    logic [11:0] req_colour;
    logic [8:0]  b_colour;
    assign req_colour = {col_a[3], col_a[2], col_a[1], col_a[0]};
    assign b_colour   = {col_b[2], col_b[1], col_b[0]};

    logic [3:0]  gnt;
    logic        rom_en, rsp_valid;
    logic [2:0]  rom_addr;
    logic [23:0] rom_rdata, rsp_rgb;
    logic [1:0]  rsp_id;

    logic [2:0]  b_gnt;
    logic        b_rom_en, b_rsp_valid;
    logic [2:0]  b_rom_addr;
    logic [23:0] b_rdata, b_p1, b_p2, b_rsp_rgb;
    logic [1:0]  b_rsp_id;

    exp_t qa[$];
    exp_t qb[$];
    int cyc = 0;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    rgb_lookup_arbiter #(.NUM_REQ(4), .ID_W(2), .ROM_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .req_colour(req_colour),
        .gnt(gnt), .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rgb(rsp_rgb)
    );

    rgb_lookup_arbiter #(.NUM_REQ(3), .ID_W(2), .ROM_LATENCY(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(b_req), .req_colour(b_colour),
        .gnt(b_gnt), .rom_en(b_rom_en), .rom_addr(b_rom_addr), .rom_rdata(b_rdata),
        .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_rgb(b_rsp_rgb)
    );

    // Behavioural ROMs: 1-edge and 3-edge read latency.
    always @(posedge clk) if (rom_en) rom_rdata <= rom_tbl[rom_addr];
    always @(posedge clk) begin
        b_p1    <= rom_tbl[b_rom_addr];
        b_p2    <= b_p1;
        b_rdata <= b_p2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed = passed + 1;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic check_rsp();
        exp_t e;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            e = qa.pop_front();
            chk("a_rsp_valid", 32'(rsp_valid), 1);
            chk("a_rsp_id", 32'(rsp_id), 32'(e.id));
            chk("a_rsp_rgb", 32'(rsp_rgb), 32'(e.rgb));
        end else begin
            chk("a_rsp_valid", 32'(rsp_valid), 0);
            chk("a_rsp_rgb", 32'(rsp_rgb), 0);
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            e = qb.pop_front();
            chk("b_rsp_valid", 32'(b_rsp_valid), 1);
            chk("b_rsp_id", 32'(b_rsp_id), 32'(e.id));
            chk("b_rsp_rgb", 32'(b_rsp_rgb), 32'(e.rgb));
        end else begin
            chk("b_rsp_valid", 32'(b_rsp_valid), 0);
            chk("b_rsp_rgb", 32'(b_rsp_rgb), 0);
        end
    endtask

    // One cycle: drive req of DUT `which` at the falling edge, check the
    // combinational grant/issue, push the expected response, then check
    // responses just after the rising edge.
    task automatic step(input int which, input logic [3:0] r, input logic [3:0] eg);
        logic [3:0] g;
        logic       e;
        logic [2:0] a;
        logic [2:0] ea;
        int         w;
        string      pfx;
        pfx = (which == 0) ? "a_" : "b_";
        if (which == 0) req = r;
        else b_req = r[2:0];
        #1;
        g = (which == 0) ? gnt : {1'b0, b_gnt};
        e = (which == 0) ? rom_en : b_rom_en;
        a = (which == 0) ? rom_addr : b_rom_addr;
        w = -1;
        for (int i = 0; i < 4; i++) if (eg[i]) w = i;
        ea = '0;
        if (w >= 0) ea = (which == 0) ? col_a[w] : col_b[w];
        chk({pfx, "gnt"}, 32'(g), 32'(eg));
        chk({pfx, "rom_en"}, 32'(e), (w >= 0) ? 1 : 0);
        chk({pfx, "rom_addr"}, 32'(a), 32'(ea));
        if (w >= 0 && which == 0) qa.push_back('{cyc + 1, 2'(w), rom_tbl[ea]});
        if (w >= 0 && which == 1) qb.push_back('{cyc + 3, 2'(w), rom_tbl[ea]});
        @(posedge clk);
        cyc++;
        #1;
        check_rsp();
        @(negedge clk);
    endtask

    initial begin
        req   = 4'b1111;
        b_req = 3'b111;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_a_gnt", 32'(gnt), 0);
        chk("rst_a_rom_en", 32'(rom_en), 0);
        chk("rst_a_rom_addr", 32'(rom_addr), 0);
        chk("rst_a_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_a_rsp_id", 32'(rsp_id), 0);
        chk("rst_a_rsp_rgb", 32'(rsp_rgb), 0);
        chk("rst_b_gnt", 32'(b_gnt), 0);
        chk("rst_b_rsp_valid", 32'(b_rsp_valid), 0);
        req   = '0;
        b_req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // single request after reset
        step(0, 4'b0001, 4'b0001);
        // all four requesting: rotation 1,2,3,0,1
        step(0, 4'b1111, 4'b0010);
        step(0, 4'b1111, 4'b0100);
        step(0, 4'b1111, 4'b1000);
        step(0, 4'b1111, 4'b0001);
        step(0, 4'b1111, 4'b0010);
        // requesters 1 and 3 only, pointer at 1
        step(0, 4'b1010, 4'b1000);
        step(0, 4'b1010, 4'b0010);
        step(0, 4'b1010, 4'b1000);
        // disabled, then resume from pointer+1 (wrap to 0)
        enable = 1'b0;
        step(0, 4'b1111, 4'b0000);
        step(0, 4'b1111, 4'b0000);
        enable = 1'b1;
        step(0, 4'b1111, 4'b0001);
        step(0, 4'b0010, 4'b0010);
        // single requester granted every cycle
        step(0, 4'b0100, 4'b0100);
        step(0, 4'b0100, 4'b0100);
        step(0, 4'b0100, 4'b0100);
        // request rising alongside another grant
        step(0, 4'b0001, 4'b0001);
        step(0, 4'b1001, 4'b1000);
        step(0, 4'b0001, 4'b0001);
        step(0, 4'b0010, 4'b0010);
        req = '0;
        // 3 requesters, latency 3
        step(1, 4'b0111, 4'b0001);
        step(1, 4'b0111, 4'b0010);
        step(1, 4'b0111, 4'b0100);
        step(1, 4'b0111, 4'b0001);
        // enable drops with reads in flight
        enable = 1'b0;
        step(1, 4'b0111, 4'b0000);
        step(1, 4'b0111, 4'b0000);
        step(1, 4'b0111, 4'b0000);
        enable = 1'b1;
        step(1, 4'b0010, 4'b0010);
        // reset during the cycle after that grant drops it
        req   = 4'b1111;
        b_req = 3'b111;
        rst_n = 1'b0;
        #1;
        chk("midrst_a_gnt", 32'(gnt), 0);
        chk("midrst_a_rom_en", 32'(rom_en), 0);
        chk("midrst_b_gnt", 32'(b_gnt), 0);
        chk("midrst_b_rom_en", 32'(b_rom_en), 0);
        qa.delete();
        qb.delete();
        @(posedge clk);
        cyc++;
        #1;
        check_rsp();
        @(negedge clk);
        req   = '0;
        b_req = '0;
        rst_n = 1'b1;
        repeat (4) step(0, 4'b0000, 4'b0000);
        step(0, 4'b0110, 4'b0010);
        req = '0;
        step(1, 4'b0110, 4'b0010);
        b_req = '0;
        repeat (4) step(0, 4'b0000, 4'b0000);
        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
